// File: rtl/if_fetch_if.sv
// Instruction memory request/response bus.
// Master side lives in if_fetch.
interface if_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding request, IF/ID register.
// Optional misaligned-PC trap: define FETCH_MISALIGN_CHECK_EN.
module if_fetch #(
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] pc,
  input  logic [5:0]  stall,
  input  logic        branch_flag,
  if_fetch_if.master  mem,
  output logic        stallreq,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        if_misalign
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DROP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;
  logic        addr_ld;
  logic        buf_ld;
  logic        buf_clr;
  logic        dlv_mem;
  logic        dlv_buf;
  logic        mis_go;
  logic        mis_pc;
  logic        lock;
  logic        lock_nxt;
  logic        unused_bits;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign mis_pc      = |pc[1:0];
  assign unused_bits = ^stall[5:2];

  // Trap lock: set by a misaligned fetch, released by redirect.
  always_ff @(posedge CLK) begin
    if (RST) lock <= 1'b0;
    else     lock <= lock_nxt;
  end

  // Misalign flag rides with the IF/ID payload.
  always_ff @(posedge CLK) begin
    if (RST)            if_misalign <= 1'b0;
    else if (!stall[1]) if_misalign <= mis_go;
  end
`else
  assign mis_pc      = 1'b0;
  assign lock        = 1'b0;
  assign if_misalign = 1'b0;
  assign unused_bits = ^{stall[5:2], pc[1:0], lock_nxt};
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, bus request, PC-hold request and datapath strobes.
  always_comb begin
    state_nxt   = state;
    addr_ld     = 1'b0;
    buf_ld      = 1'b0;
    buf_clr     = 1'b0;
    dlv_mem     = 1'b0;
    dlv_buf     = 1'b0;
    mis_go      = 1'b0;
    lock_nxt    = lock;
    mem.mem_req = 1'b0;
    stallreq    = 1'b1;
    unique case (state)
      IDLE: begin
        if (lock) begin
          if (branch_flag) lock_nxt = 1'b0;
        end else if (mis_pc) begin
          if (!stall[1] && !branch_flag) begin
            mis_go   = 1'b1;
            lock_nxt = 1'b1;
          end
        end else if (!stall[0] && !branch_flag) begin
          addr_ld   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ack) begin
          state_nxt = IDLE;
          if (!branch_flag) begin
            stallreq = 1'b0;
            if (stall[1]) begin
              buf_ld    = 1'b1;
              state_nxt = HOLD;
            end else begin
              dlv_mem = 1'b1;
            end
          end
        end else if (branch_flag) begin
          state_nxt = DROP;
        end
      end
      HOLD: begin
        if (branch_flag) begin
          buf_clr   = 1'b1;
          state_nxt = IDLE;
        end else if (!stall[1]) begin
          dlv_buf   = 1'b1;
          buf_clr   = 1'b1;
          state_nxt = IDLE;
        end
      end
      DROP: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request address, latched once per fetch.
  always_ff @(posedge CLK) begin
    if (RST)          mem.mem_addr <= 32'h0;
    else if (addr_ld) mem.mem_addr <= {pc[31:2], 2'b00};
  end

  // Hold buffer for a response that arrived while IF/ID was stalled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_pc   <= 32'h0;
      hold_inst <= 32'h0;
    end else if (buf_ld) begin
      hold_pc   <= mem.mem_addr;
      hold_inst <= mem.mem_rdata;
    end else if (buf_clr) begin
      hold_pc   <= 32'h0;
      hold_inst <= 32'h0;
    end
  end

  // IF/ID payload: hold on stall, else deliver or bubble.
  always_ff @(posedge CLK) begin
    if (RST) begin
      if_pc    <= 32'h0;
      if_inst  <= NOP_INST;
      if_valid <= 1'b0;
    end else if (!stall[1]) begin
      unique case (1'b1)
        dlv_mem: begin
          if_pc    <= mem.mem_addr;
          if_inst  <= mem.mem_rdata;
          if_valid <= 1'b1;
        end
        dlv_buf: begin
          if_pc    <= hold_pc;
          if_inst  <= hold_inst;
          if_valid <= 1'b1;
        end
        mis_go: begin
          if_pc    <= pc;
          if_inst  <= NOP_INST;
          if_valid <= 1'b1;
        end
        default: begin
          if_pc    <= 32'h0;
          if_inst  <= NOP_INST;
          if_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed table plus randomized run
// against a transaction-level fetch model.
module tb_if_fetch;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] pc = '0;
  logic [5:0]  stall = '0;
  logic        branch_flag = 1'b0;
  logic        stallreq;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        if_misalign;

  if_fetch_if mem_bus ();

  if_fetch #(.NOP_INST(NOP)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .pc          (pc),
    .stall       (stall),
    .branch_flag (branch_flag),
    .mem         (mem_bus),
    .stallreq    (stallreq),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .if_valid    (if_valid),
    .if_misalign (if_misalign)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic [5:0]  st;
    logic        bf;
    logic        ack;
    logic [31:0] rd;
    logic        chk;
    logic        req;
    logic [31:0] addr;
    logic        sreq;
    logic        val;
    logic [31:0] ipc;
    logic [31:0] inst;
    logic        mis;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;

  // transaction-level model state
  bit          m_pend;
  bit          m_poison;
  logic [31:0] m_paddr;
  bit          m_rdy;
  logic [31:0] m_rpc;
  logic [31:0] m_rinst;
  logic [31:0] m_maddr;
  logic [31:0] m_ipc;
  logic [31:0] m_iinst;
  bit          m_ival;

  function automatic vec_t mk(
    logic r, logic [31:0] p, logic [5:0] s,
    logic b, logic a, logic [31:0] d, logic c,
    logic q, logic [31:0] ad, logic sr,
    logic v, logic [31:0] ip, logic [31:0] in,
    logic mi);
    vec_t x;
    x.rst = r;  x.pc = p;    x.st = s;
    x.bf = b;   x.ack = a;   x.rd = d;
    x.chk = c;  x.req = q;   x.addr = ad;
    x.sreq = sr; x.val = v;  x.ipc = ip;
    x.inst = in; x.mis = mi;
    return x;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic drive(logic r, logic [31:0] p,
                       logic [5:0] s, logic b,
                       logic a, logic [31:0] d);
    @(negedge CLK);
    RST               = r;
    pc                = p;
    stall             = s;
    branch_flag       = b;
    mem_bus.mem_ack   = a;
    mem_bus.mem_rdata = d;
    #1;
  endtask

  task automatic run_vec(vec_t v, string tag);
    drive(v.rst, v.pc, v.st, v.bf, v.ack, v.rd);
    if (v.chk) begin
      chk({tag, ".req"},  32'(mem_bus.mem_req), 32'(v.req));
      chk({tag, ".addr"}, mem_bus.mem_addr, v.addr);
      chk({tag, ".sreq"}, 32'(stallreq), 32'(v.sreq));
      chk({tag, ".val"},  32'(if_valid), 32'(v.val));
      chk({tag, ".pc"},   if_pc, v.ipc);
      chk({tag, ".inst"}, if_inst, v.inst);
      chk({tag, ".mis"},  32'(if_misalign), 32'(v.mis));
    end
  endtask

  task automatic model_reset();
    m_pend   = 0; m_poison = 0; m_paddr = '0;
    m_rdy    = 0; m_rpc    = '0; m_rinst = '0;
    m_maddr  = '0;
    m_ipc    = '0; m_iinst = NOP; m_ival = 0;
  endtask

  // one clock of the fetch transaction model
  task automatic model_step(logic r, logic [31:0] p,
                            logic [5:0] s, logic b,
                            logic a, logic [31:0] d);
    bit          got;
    logic [31:0] gpc;
    logic [31:0] gin;
    got = 0; gpc = '0; gin = '0;
    if (r) begin
      model_reset();
      return;
    end
    if (m_pend) begin
      if (a) begin
        m_pend = 0;
        if (!m_poison && !b) begin
          if (!s[1]) begin
            got = 1; gpc = m_paddr; gin = d;
          end else begin
            m_rdy = 1; m_rpc = m_paddr; m_rinst = d;
          end
        end
      end else if (b) begin
        m_poison = 1;
      end
    end else if (m_rdy) begin
      if (b) begin
        m_rdy = 0;
      end else if (!s[1]) begin
        m_rdy = 0; got = 1;
        gpc = m_rpc; gin = m_rinst;
      end
    end else if (!s[0] && !b) begin
      m_pend   = 1;
      m_poison = 0;
      m_paddr  = p & 32'hFFFF_FFFC;
      m_maddr  = m_paddr;
    end
    if (!s[1]) begin
      m_ival  = got;
      m_ipc   = got ? gpc : 32'h0;
      m_iinst = got ? gin : NOP;
    end
  endtask

  initial begin
    logic        r;
    logic        b;
    logic        a;
    logic [5:0]  s;
    logic [31:0] p;
    logic [31:0] d;
    bit          esr;

    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = '0;

    // basic fetch, ack one cycle after request
    tbl.push_back(mk(1,0,0,0,0,0, 0, 0,0,1,0,0,NOP,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1, 0,0,1,0,0,NOP,0));
    tbl.push_back(mk(0,0,0,0,1,32'h00500093,
                     1, 1,0,0,0,0,NOP,0));
    tbl.push_back(mk(0,4,0,0,0,0, 1,
                     0,0,1,1,0,32'h00500093,0));
    // ack delayed three cycles
    tbl.push_back(mk(0,4,0,0,0,0, 1, 1,4,1,0,0,NOP,0));
    tbl.push_back(mk(0,4,0,0,0,0, 1, 1,4,1,0,0,NOP,0));
    tbl.push_back(mk(0,4,0,0,0,0, 1, 1,4,1,0,0,NOP,0));
    tbl.push_back(mk(0,4,0,0,1,32'h00a00113,
                     1, 1,4,0,0,0,NOP,0));
    tbl.push_back(mk(0,8,0,0,0,0, 1,
                     0,4,1,1,4,32'h00a00113,0));
    // redirect while waiting: DROP discards response
    tbl.push_back(mk(0,8,0,1,0,0, 1, 1,8,1,0,0,NOP,0));
    tbl.push_back(mk(0,32'h100,0,0,0,0,
                     1, 1,8,1,0,0,NOP,0));
    tbl.push_back(mk(0,32'h100,0,0,1,32'hDEADBEEF,
                     1, 1,8,1,0,0,NOP,0));
    tbl.push_back(mk(0,32'h100,0,0,0,0,
                     1, 0,8,1,0,0,NOP,0));
    tbl.push_back(mk(0,32'h100,0,0,1,32'h11111111,
                     1, 1,32'h100,0,0,0,NOP,0));
    tbl.push_back(mk(0,32'h104,0,0,0,0, 1,
                     0,32'h100,1,1,32'h100,32'h11111111,0));
    // response under IF/ID stall goes to hold buffer
    tbl.push_back(mk(0,32'h104,6'b10,0,1,32'h22222222,
                     1, 1,32'h104,0,0,0,NOP,0));
    tbl.push_back(mk(0,32'h104,6'b10,0,0,0,
                     1, 0,32'h104,1,0,0,NOP,0));
    tbl.push_back(mk(0,32'h104,6'b10,0,0,0,
                     1, 0,32'h104,1,0,0,NOP,0));
    tbl.push_back(mk(0,32'h104,0,0,0,0,
                     1, 0,32'h104,1,0,0,NOP,0));
    tbl.push_back(mk(0,32'h108,0,0,0,0, 1,
                     0,32'h104,1,1,32'h104,32'h22222222,0));
    // reset during REQ, late ack ignored
    tbl.push_back(mk(0,32'h108,0,0,0,0,
                     1, 1,32'h108,1,0,0,NOP,0));
    tbl.push_back(mk(1,32'h108,0,0,0,0,
                     1, 1,32'h108,1,0,0,NOP,0));
    tbl.push_back(mk(0,32'h108,6'b01,0,1,32'h33333333,
                     1, 0,0,1,0,0,NOP,0));
    tbl.push_back(mk(0,32'h108,6'b01,0,0,0,
                     1, 0,0,1,0,0,NOP,0));
`ifdef FETCH_MISALIGN_CHECK_EN
    // misaligned pc: trap, then locked until redirect
    tbl.push_back(mk(1,32'h102,0,0,0,0, 0, 0,0,1,0,0,NOP,0));
    tbl.push_back(mk(0,32'h102,0,0,0,0, 1, 0,0,1,0,0,NOP,0));
    tbl.push_back(mk(0,32'h102,0,0,0,0,
                     1, 0,0,1,1,32'h102,NOP,1));
    tbl.push_back(mk(0,32'h102,0,0,0,0, 1, 0,0,1,0,0,NOP,0));
    tbl.push_back(mk(0,32'h102,0,1,0,0, 1, 0,0,1,0,0,NOP,0));
    tbl.push_back(mk(0,32'h200,0,0,0,0, 1, 0,0,1,0,0,NOP,0));
    tbl.push_back(mk(0,32'h200,0,0,0,0,
                     1, 1,32'h200,1,0,0,NOP,0));
`endif

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("t%0d", i));

    // randomized run against the model
    drive(1, 0, 0, 0, 0, 0);
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      r    = ($urandom_range(0, 199) == 0);
      p    = $urandom() & 32'hFFFF_FFFC;
      s    = 6'($urandom());
      s[0] = ($urandom_range(0, 9) < 3);
      s[1] = ($urandom_range(0, 9) < 3);
      b    = ($urandom_range(0, 9) == 0);
      a    = ($urandom_range(0, 9) < 4);
      d    = $urandom();
      drive(r, p, s, b, a, d);
      esr = !(m_pend && !m_poison && a && !b);
      chk("r.req",  32'(mem_bus.mem_req), 32'(m_pend));
      chk("r.addr", mem_bus.mem_addr, m_maddr);
      chk("r.sreq", 32'(stallreq), 32'(esr));
      chk("r.val",  32'(if_valid), 32'(m_ival));
      chk("r.pc",   if_pc, m_ipc);
      chk("r.inst", if_inst, m_iinst);
      chk("r.mis",  32'(if_misalign), 32'h0);
      model_step(r, p, s, b, a, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter NOP_INST, 32'h00000013, bubble instruction driven on if_inst when no valid instruction is presented.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 pc  input  32  current fetch address from PC register.
REQ-005 stall  input  6  pipeline stall vector; stall[0] = PC held, stall[1] = IF/ID held.
REQ-006 branch_flag  input  1  redirect from decode; in-flight/buffered fetches are wrong-path.
REQ-007 mem_req  output  1  instruction memory request.
REQ-008 mem_addr  output  32  word-aligned request address, registered.
REQ-009 mem_ack  input  1  memory response valid; sampled only while mem_req=1.
REQ-010 mem_rdata  input  32  instruction word, valid when mem_ack=1.
REQ-011 stallreq  output  1  to control; requests PC hold while fetch incomplete.
REQ-012 if_pc / if_inst / if_valid  output  32/32/1  registered IF/ID payload.
REQ-013 if_misalign  output  1  misaligned-fetch flag (see Configuration).

Function
REQ-014 FSM states IDLE, REQ, HOLD, DROP; mem_req=1 exactly in REQ and DROP, combinational from state.
REQ-015 IDLE: if stall[0]=0 and branch_flag=0, latch mem_addr<={pc[31:2],2'b00}, go REQ; else stay IDLE.
REQ-016 REQ: mem_addr stable until mem_ack; ack allowed same cycle REQ entered (min request-to-response 1 cycle).
REQ-017 REQ, mem_ack=1, branch_flag=0, stall[1]=0: next edge if_pc<=mem_addr, if_inst<=mem_rdata, if_valid<=1; go IDLE.
REQ-018 REQ, mem_ack=1, branch_flag=0, stall[1]=1: capture {mem_addr,mem_rdata} in hold buffer; go HOLD.
REQ-019 REQ, mem_ack=1, branch_flag=1: discard response; go IDLE.
REQ-020 REQ, mem_ack=0, branch_flag=1: go DROP; request not withdrawn.
REQ-021 DROP: mem_req=1, same mem_addr; on mem_ack discard data, go IDLE; further branch_flag stays DROP.
REQ-022 HOLD: when stall[1]=0 and branch_flag=0, move buffer to IF/ID outputs with if_valid=1, go IDLE; branch_flag=1 discards buffer, go IDLE.
REQ-023 stallreq=1 in all states except REQ cycle with mem_ack=1 and branch_flag=0; throughput max one instruction per 2 cycles.
REQ-024 IF/ID outputs hold when stall[1]=1; when stall[1]=0 and no instruction delivered (incl. branch_flag=1), next edge if_pc<=0, if_inst<=NOP_INST, if_valid<=0.
REQ-025 branch_flag simultaneous with stall[1]=1: outputs hold; buffer/in-flight data still discarded per REQ-019..022.

Reset
REQ-026 RST=1 at edge: state<=IDLE, mem_addr<=0, if_pc<=0, if_inst<=NOP_INST, if_valid<=0, if_misalign<=0, hold buffer cleared; overrides all other inputs.
REQ-027 RST mid-REQ/DROP: mem_req drops the cycle after reset edge; mem_ack arriving in IDLE/HOLD ignored.

Configuration
REQ-028 Macro FETCH_MISALIGN_CHECK_EN defined: in IDLE with pc[1:0]!=0 and stall[1]=0, no request; next edge if_pc<=pc, if_inst<=NOP_INST, if_valid<=1, if_misalign<=1 for one cycle, then FSM stays IDLE with stallreq=1 until branch_flag.
REQ-029 Macro not defined: pc[1:0] ignored, if_misalign tied 0, no check logic.

Verification
REQ-030 Reset, pc=0, mem_ack one cycle after req, rdata=32'h00500093 -> mem_addr=0, if_pc=0, if_inst=32'h00500093, if_valid=1; stallreq low only in ack cycle.
REQ-031 mem_ack delayed 3 cycles -> mem_req, mem_addr=0x4 stable all 4 cycles, stallreq=1 throughout wait, if_valid=0 until delivery.
REQ-032 branch_flag=1 while REQ waiting, ack 2 cycles later with 32'hDEADBEEF -> DROP, data discarded, if_valid=0, next request uses new pc (target 0x100).
REQ-033 ack with stall[1]=1 for 3 cycles -> HOLD, outputs unchanged; stall[1] falls -> buffered instruction appears next edge, if_valid=1.
REQ-034 RST asserted during REQ, ack arrives after -> ignored; outputs reset values, if_inst=NOP_INST.
REQ-035 With FETCH_MISALIGN_CHECK_EN, pc=0x102 -> no mem_req, if_misalign=1 one cycle, if_pc=0x102; stall held until branch_flag.
